// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the RV32I 5-stage core: boot hold, MEM freeze, redirect refill,
// load-use and fetch-wait stalls, plus wrap-around stall/flush counters.
module hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int FETCH_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        imem_valid,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {BOOT, RUN, REFILL} state_t;

  localparam logic [3:0] BOOT_INIT   = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] REFILL_INIT = (FETCH_LAT > 0) ? 4'(FETCH_LAT - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] stall_q, flush_q;
  logic        stall_inc, flush_inc;
  logic        load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= BOOT;
      cnt     <= BOOT_INIT;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_inc) stall_q <= stall_q + 32'd1;
      if (flush_inc) flush_q <= flush_q + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == BOOT) begin
      if (cnt == 4'd0) state_nxt = RUN;
      else             cnt_nxt   = cnt - 4'd1;
    end else if (dmem_stall) begin
      // full freeze: a pending redirect is held upstream and retried
    end else if (ex_redirect) begin
      if (FETCH_LAT > 0) begin
        state_nxt = REFILL;
        cnt_nxt   = REFILL_INIT;
      end else begin
        state_nxt = RUN;
      end
    end else if (state == REFILL) begin
      if (cnt == 4'd0) state_nxt = RUN;
      else             cnt_nxt   = cnt - 4'd1;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    // BOOT values also show while reset is asserted, before the state register settles
    if (!reset_n || state == BOOT) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (dmem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      stall_inc = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc   = 1'b1;
    end else if (state == REFILL) begin
      if_id_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      stall_inc   = 1'b1;
    end else if (!imem_valid) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (BOOT_CYCLES=4, FETCH_LAT=2): vector table plus
// hand-written multi-cycle sequences for boot, redirect, freeze and counter wrap.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, imem_valid, dmem_stall;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic [31:0] stall_count, flush_count;

  int passed = 0;
  int total  = 0;

  // outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush}
  localparam logic [4:0] O_BOOT   = 5'b00111;
  localparam logic [4:0] O_NORM   = 5'b11010;
  localparam logic [4:0] O_REDIR  = 5'b11111;
  localparam logic [4:0] O_REFILL = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00000;
  localparam logic [4:0] O_IMEM   = 5'b01110;

  hazard_ctrl #(.BOOT_CYCLES(4), .FETCH_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .imem_valid(imem_valid), .dmem_stall(dmem_stall),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, iv, ds;
    logic [4:0] exp;
    logic       inc;
  } vec_t;

  vec_t vt[10];

  function automatic logic [4:0] outs();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0; imem_valid = 1'b1; dmem_stall = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic chk_outs(input string name, input logic [4:0] exp);
    @(negedge clk);
    chk(name, 32'(outs()), 32'(exp));
  endtask

  logic [31:0] s0, f0;

  initial begin
    vt[0] = '{"normal",       5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, O_NORM,   1'b0};
    vt[1] = '{"loaduse_rs2",  5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'b00011, 1'b1};
    vt[2] = '{"loaduse_rs1",  5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 5'b00011, 1'b1};
    vt[3] = '{"rd_zero",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, O_NORM,   1'b0};
    vt[4] = '{"not_used",     5'd9, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, O_NORM,   1'b0};
    vt[5] = '{"not_load",     5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, O_NORM,   1'b0};
    vt[6] = '{"imem_wait",    5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, O_IMEM,   1'b1};
    vt[7] = '{"dmem_freeze",  5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, O_FREEZE, 1'b1};
    vt[8] = '{"lu_over_imem", 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'b00011, 1'b1};
    vt[9] = '{"dmem_over_lu", 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, O_FREEZE, 1'b1};

    // reset and boot hold
    idle();
    reset_n = 1'b0;
    chk_outs("reset_outs", O_BOOT);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall0", stall_count, 32'd0);
    chk("reset_flush0", flush_count, 32'd0);
    reset_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      chk_outs($sformatf("boot_c%0d", c), O_BOOT);
      next_cycle();
    end
    chk_outs("boot_c5_run", O_NORM);
    chk("boot_stall", stall_count, 32'd0);

    // single-cycle vector table in RUN
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; id_uses_rs1 = vt[i].u1; id_uses_rs2 = vt[i].u2;
      ex_rd = vt[i].rd; ex_mem_read = vt[i].mr; imem_valid = vt[i].iv; dmem_stall = vt[i].ds;
      s0 = stall_count;
      chk_outs(vt[i].name, vt[i].exp);
      next_cycle();
      chk({vt[i].name, "_cnt"}, stall_count, s0 + 32'(vt[i].inc));
      idle();
    end

    // redirect with FETCH_LAT=2
    next_cycle();
    f0 = flush_count;
    ex_redirect = 1'b1;
    chk_outs("redir_c0", O_REDIR);
    next_cycle(); ex_redirect = 1'b0;
    chk_outs("redir_c1", O_REFILL);
    next_cycle();
    chk_outs("redir_c2", O_REFILL);
    next_cycle();
    chk_outs("redir_c3", O_NORM);
    chk("redir_flushcnt", flush_count, f0 + 32'd1);

    // redirect again at the second refill cycle restarts the refill
    next_cycle();
    f0 = flush_count;
    ex_redirect = 1'b1;
    chk_outs("rr_c0", O_REDIR);
    next_cycle(); ex_redirect = 1'b0;
    chk_outs("rr_c1", O_REFILL);
    next_cycle(); ex_redirect = 1'b1;
    chk_outs("rr_c2_redir", O_REDIR);
    next_cycle(); ex_redirect = 1'b0;
    chk_outs("rr_c3", O_REFILL);
    next_cycle();
    chk_outs("rr_c4", O_REFILL);
    next_cycle();
    chk_outs("rr_c5", O_NORM);
    chk("rr_flushcnt", flush_count, f0 + 32'd2);

    // simultaneous freeze and redirect: redirect waits for dmem_stall to drop
    next_cycle();
    s0 = stall_count; f0 = flush_count;
    dmem_stall = 1'b1; ex_redirect = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      chk_outs($sformatf("frz_c%0d", c), O_FREEZE);
      next_cycle();
    end
    dmem_stall = 1'b0;
    chk_outs("frz_c4_redir", O_REDIR);
    next_cycle(); ex_redirect = 1'b0;
    chk_outs("frz_refill", O_REFILL);
    chk("frz_stallcnt", stall_count, s0 + 32'd3);
    chk("frz_flushcnt", flush_count, f0 + 32'd1);
    next_cycle();
    next_cycle();

    // fetch wait for 2 cycles
    s0 = stall_count;
    imem_valid = 1'b0;
    chk_outs("imem_c1", O_IMEM);
    next_cycle();
    chk_outs("imem_c2", O_IMEM);
    next_cycle(); imem_valid = 1'b1;
    chk_outs("imem_done", O_NORM);
    chk("imem_stallcnt", stall_count, s0 + 32'd2);

    // counter wrap
    next_cycle();
    dut.stall_q = 32'hFFFF_FFFF;
    imem_valid = 1'b0;
    next_cycle(); imem_valid = 1'b1;
    chk("stall_wrap", stall_count, 32'd0);

    // reset mid-refill discards state and counters
    next_cycle();
    ex_redirect = 1'b1;
    next_cycle(); ex_redirect = 1'b0;
    reset_n = 1'b0;
    chk_outs("rst_refill_outs", O_BOOT);
    next_cycle(); reset_n = 1'b1;
    chk_outs("rst_refill_boot", O_BOOT);
    chk("rst_refill_flush", flush_count, 32'd0);
    chk("rst_refill_stall", stall_count, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
